// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory stage: RAM sequencer with wait states plus KBSR/KBDR/DSR/DDR device page.
// Latency accept->rdy: RAM read W+3, RAM write W+2, device 1; the core holds req_valid until rdy.
module lc3_mem_ctrl #(
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] MMIO_BASE   = 16'hFE00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rdy,
    output logic [15:0]       rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              dsp_valid,
    output logic [7:0]        dsp_data,
    input  logic              dsp_ready
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_l_q, we_l_d;
    logic               rdy_q, rdy_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               ram_en_q, ram_en_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [15:0]        ram_wdata_q, ram_wdata_d;
    logic               kb_ready_q, kb_ready_d;
    logic               kb_ovr_q, kb_ovr_d;
    logic [7:0]         kbdr_q, kbdr_d;
    logic               dsp_valid_q, dsp_valid_d;
    logic [7:0]         dsp_data_q, dsp_data_d;

    logic               is_dev;
    logic [15:0]        dev_off;
    logic               mmio;
    logic               kbdr_rd;
    logic               ddr_wr;
    logic [15:0]        mmio_rdata;

    assign is_dev  = (req_addr >= MMIO_BASE);
    assign dev_off = req_addr - MMIO_BASE;
    assign mmio    = (state_q == S_IDLE) && req_valid && is_dev;
    assign kbdr_rd = mmio && !req_we && (dev_off == 16'd2);
    assign ddr_wr  = mmio && req_we && (dev_off == 16'd6);

    always_comb begin
        mmio_rdata = 16'h0000;
        case (dev_off)
            16'd0:   mmio_rdata = {kb_ready_q, kb_ovr_q, 14'b0};
            16'd2:   mmio_rdata = {8'b0, kbdr_q};
            16'd4:   mmio_rdata = {~dsp_valid_q, 15'b0};
            default: mmio_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_l_d      = we_l_q;
        rdy_d       = 1'b0;
        rdata_d     = rdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (is_dev) begin
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        if (!req_we) begin
                            rdata_d = mmio_rdata;
                        end
                    end else begin
                        we_l_d      = req_we;
                        ram_addr_d  = req_addr[ADDR_W-1:0];
                        ram_wdata_d = req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_d  = S_ACCESS;
                            ram_en_d = 1'b1;
                            ram_we_d = req_we;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
            end
            S_WAIT: begin
                // Counter holds the wait cycles still owed including this one.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = S_ACCESS;
                    ram_en_d = 1'b1;
                    ram_we_d = we_l_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                state_d = we_l_q ? S_DONE : S_CAPTURE;
                rdy_d   = we_l_q;
            end
            S_CAPTURE: begin
                rdata_d = ram_rdata;
                state_d = S_DONE;
                rdy_d   = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A KBDR read on the same edge as a new key frees the buffer, so the key is taken.
    always_comb begin
        kb_ready_d = kb_ready_q;
        kb_ovr_d   = kb_ovr_q;
        kbdr_d     = kbdr_q;
        if (kbdr_rd) begin
            kb_ready_d = 1'b0;
            kb_ovr_d   = 1'b0;
        end
        if (kb_valid) begin
            if (kbdr_rd || !kb_ready_q) begin
                kbdr_d     = kb_data;
                kb_ready_d = 1'b1;
            end else begin
                kb_ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
        end
        if (ddr_wr && (!dsp_valid_q || dsp_ready)) begin
            dsp_valid_d = 1'b1;
            dsp_data_d  = req_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_l_q      <= 1'b0;
            rdy_q       <= 1'b0;
            rdata_q     <= 16'h0000;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 16'h0000;
            kb_ready_q  <= 1'b0;
            kb_ovr_q    <= 1'b0;
            kbdr_q      <= 8'h00;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_l_q      <= we_l_d;
            rdy_q       <= rdy_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            kb_ready_q  <= kb_ready_d;
            kb_ovr_q    <= kb_ovr_d;
            kbdr_q      <= kbdr_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
        end
    end

    assign rdy       = rdy_q;
    assign rdata     = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: one instance with two wait states, one with none, each backed by a small sync RAM.
module tb_lc3_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance with WAIT_CYCLES=2 (suffix 1) and WAIT_CYCLES=0 (suffix 0).
    logic        req_valid1 = 0, req_we1 = 0;
    logic [15:0] req_addr1 = 0, req_wdata1 = 0;
    logic        rdy1, ram_en1, ram_we1, dsp_valid1;
    logic [15:0] rdata1, ram_wdata1, ram_addr1;
    logic [15:0] ram_rdata1 = 0;
    logic [7:0]  dsp_data1;
    logic        kb_valid = 0, dsp_ready = 0;
    logic [7:0]  kb_data = 0;

    logic        req_valid0 = 0, req_we0 = 0;
    logic [15:0] req_addr0 = 0, req_wdata0 = 0;
    logic        rdy0, ram_en0, ram_we0, dsp_valid0;
    logic [15:0] rdata0, ram_wdata0, ram_addr0;
    logic [15:0] ram_rdata0 = 0;
    logic [7:0]  dsp_data0;
    logic        kb_valid0 = 0, dsp_ready0 = 0;
    logic [7:0]  kb_data0 = 0;

    lc3_mem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(2), .MMIO_BASE(16'hFE00)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rdy(rdy1), .rdata(rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1),
        .kb_valid(kb_valid), .kb_data(kb_data),
        .dsp_valid(dsp_valid1), .dsp_data(dsp_data1), .dsp_ready(dsp_ready)
    );

    lc3_mem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(0), .MMIO_BASE(16'hFE00)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rdy(rdy0), .rdata(rdata0),
        .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata0),
        .kb_valid(kb_valid0), .kb_data(kb_data0),
        .dsp_valid(dsp_valid0), .dsp_data(dsp_data0), .dsp_ready(dsp_ready0)
    );

    logic [15:0] mem1 [256];
    logic [15:0] mem0 [256];
    int we_cnt1 = 0, we_cnt0 = 0;

    always @(posedge clk) begin
        if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1[7:0]] <= ram_wdata1;
            else         ram_rdata1 <= mem1[ram_addr1[7:0]];
        end
        if (ram_en0) begin
            if (ram_we0) mem0[ram_addr0[7:0]] <= ram_wdata0;
            else         ram_rdata0 <= mem0[ram_addr0[7:0]];
        end
        if (ram_we1) we_cnt1++;
        if (ram_we0) we_cnt0++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    typedef struct {
        logic [15:0] rd;
        bit          chk_rd;
        int          lat;
        int          ram_wr;
    } exp_t;
    exp_t sb_q[$];

    // kb_mode: 0 none, 1 key pulse before the request, 2 key on the accept edge.
    task automatic run_req(input bit inst, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp_rd, input bit chk_rd,
                           input int exp_lat, input int kb_mode, input logic [7:0] kb_d,
                           input string tag);
        exp_t e;
        int   n;
        bit   got;
        int   we_start;
        e.rd     = exp_rd;
        e.chk_rd = chk_rd;
        e.lat    = exp_lat;
        e.ram_wr = (we && addr < 16'hFE00) ? 1 : 0;
        sb_q.push_back(e);
        we_start = inst ? we_cnt1 : we_cnt0;
        @(posedge clk); #1;
        if (kb_mode == 1) begin
            kb_valid = 1; kb_data = kb_d;
            @(posedge clk); #1;
            kb_valid = 0;
        end
        if (inst) begin
            req_valid1 = 1; req_we1 = we; req_addr1 = addr; req_wdata1 = wd;
        end else begin
            req_valid0 = 1; req_we0 = we; req_addr0 = addr; req_wdata0 = wd;
        end
        if (kb_mode == 2) begin
            kb_valid = 1; kb_data = kb_d;
        end
        @(posedge clk); #1;
        kb_valid = 0;
        n   = 1;
        got = 0;
        while (!got && n <= 40) begin
            if (inst ? rdy1 : rdy0) got = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        req_valid1 = 0;
        req_valid0 = 0;
        e = sb_q.pop_front();
        if (!got) begin
            chk({tag, " rdy timeout"}, 32'(n), 32'(e.lat));
        end else begin
            chk({tag, " latency"}, 32'(n), 32'(e.lat));
            if (e.chk_rd) chk({tag, " rdata"}, {16'h0, inst ? rdata1 : rdata0}, {16'h0, e.rd});
            chk({tag, " ram_we cycles"}, 32'((inst ? we_cnt1 : we_cnt0) - we_start), 32'(e.ram_wr));
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        bit          chk_rd;
        int          lat;
        int          kb_mode;
        logic [7:0]  kb_d;
    } vec_t;
    vec_t vecs [16];

    initial begin
        int rdy_start;
        int we_start;

        vecs[0]  = '{1'b1, 16'h3000, 16'h1234, 16'h0000, 1'b0, 4, 0, 8'h00};
        vecs[1]  = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 5, 0, 8'h00};
        vecs[2]  = '{1'b1, 16'h3001, 16'hABCD, 16'h1234, 1'b1, 4, 0, 8'h00};
        vecs[3]  = '{1'b0, 16'h3001, 16'h0000, 16'hABCD, 1'b1, 5, 0, 8'h00};
        vecs[4]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b1, 1, 0, 8'h00};
        vecs[5]  = '{1'b0, 16'hFE00, 16'h0000, 16'h8000, 1'b1, 1, 1, 8'h41};
        vecs[6]  = '{1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b1, 1, 0, 8'h00};
        vecs[7]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b1, 1, 0, 8'h00};
        vecs[8]  = '{1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b1, 1, 1, 8'h41};
        vecs[9]  = '{1'b0, 16'hFE00, 16'h0000, 16'hC000, 1'b1, 1, 1, 8'h42};
        vecs[10] = '{1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b1, 1, 2, 8'h43};
        vecs[11] = '{1'b0, 16'hFE00, 16'h0000, 16'h8000, 1'b1, 1, 0, 8'h00};
        vecs[12] = '{1'b0, 16'hFE02, 16'h0000, 16'h0043, 1'b1, 1, 0, 8'h00};
        vecs[13] = '{1'b1, 16'hFE00, 16'hFFFF, 16'h0043, 1'b1, 1, 0, 8'h00};
        vecs[14] = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b1, 1, 0, 8'h00};
        vecs[15] = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 5, 0, 8'h00};

        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdy", {31'h0, rdy1}, 0);
        chk("reset ram_en", {31'h0, ram_en1}, 0);
        chk("reset ram_we", {31'h0, ram_we1}, 0);
        chk("reset dsp_valid", {31'h0, dsp_valid1}, 0);
        chk("reset rdata", {16'h0, rdata1}, 0);
        chk("reset ram_addr", {16'h0, ram_addr1}, 0);
        chk("reset dsp_data", {24'h0, dsp_data1}, 0);
        chk("reset rdata w0", {16'h0, rdata0}, 0);
        rst = 0;

        for (int i = 0; i < 16; i++) begin
            run_req(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].chk_rd,
                    vecs[i].lat, vecs[i].kb_mode, vecs[i].kb_d, $sformatf("vec%0d", i));
        end

        // No-wait-state instance: seed two words, then back-to-back reads.
        run_req(1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0, 2, 0, 8'h00, "w0 wr0");
        run_req(1'b0, 1'b1, 16'h0001, 16'h2222, 16'h0000, 1'b0, 2, 0, 8'h00, "w0 wr1");
        run_req(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b1, 3, 0, 8'h00, "w0 rd0");
        run_req(1'b0, 1'b0, 16'h0001, 16'h0000, 16'h2222, 1'b1, 3, 0, 8'h00, "w0 rd1");

        // Display: stalled display keeps the first char and ignores a second DDR write.
        dsp_ready = 0;
        run_req(1'b1, 1'b1, 16'hFE06, 16'h0158, 16'h0000, 1'b0, 1, 0, 8'h00, "ddr wr1");
        chk("dsp_valid after ddr", {31'h0, dsp_valid1}, 1);
        chk("dsp_data after ddr", {24'h0, dsp_data1}, 32'h58);
        run_req(1'b1, 1'b0, 16'hFE04, 16'h0000, 16'h0000, 1'b1, 1, 0, 8'h00, "dsr busy");
        run_req(1'b1, 1'b1, 16'hFE06, 16'h0163, 16'h0000, 1'b0, 1, 0, 8'h00, "ddr wr2");
        chk("dsp_data held", {24'h0, dsp_data1}, 32'h58);
        @(posedge clk); #1;
        dsp_ready = 1;
        @(posedge clk); #1;
        dsp_ready = 0;
        chk("dsp_valid drained", {31'h0, dsp_valid1}, 0);
        run_req(1'b1, 1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b1, 1, 0, 8'h00, "dsr idle");

        // Reset while a RAM write sits in WAIT: nothing may reach the RAM or the core.
        rdy_start = 0;
        we_start  = we_cnt1;
        @(posedge clk); #1;
        req_valid1 = 1; req_we1 = 1; req_addr1 = 16'h3005; req_wdata1 = 16'h5555;
        @(posedge clk); #1;
        rst = 1;
        req_valid1 = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            if (rdy1) rdy_start++;
            @(posedge clk); #1;
        end
        chk("rst abort rdy", 32'(rdy_start), 0);
        chk("rst abort ram_we", 32'(we_cnt1 - we_start), 0);
        chk("rst abort dsp_valid", {31'h0, dsp_valid1}, 0);
        run_req(1'b1, 1'b0, 16'hFE10, 16'h0000, 16'h0000, 1'b1, 1, 0, 8'h00, "post-rst FE10");
        run_req(1'b1, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b1, 1, 0, 8'h00, "post-rst KBSR");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
